// File: rtl/dtw_stream_core.sv
// Streaming DTW core: loads a reference over AXIS, updates one DP row per query sample,
// and emits {cost, end position} as a two-beat packet when the query ends.
module dtw_stream_core #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int COST_WIDTH      = 24,
    parameter int REF_MAX         = 256,
    parameter int POS_WIDTH       = $clog2(REF_MAX)
) (
    input  logic                       i_axis_clk,
    input  logic                       i_axis_rst,
    input  logic                       i_mode,
    input  logic                       i_axis_in_tuser,
    input  logic                       i_axis_in_tvalid,
    output logic                       o_axis_in_tready,
    input  logic                       i_axis_in_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0] i_axis_in_tdata,
    output logic                       o_axis_out_tuser,
    output logic                       o_axis_out_tvalid,
    input  logic                       i_axis_out_tready,
    output logic                       o_axis_out_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
    output logic [POS_WIDTH:0]         o_ref_len,
    output logic                       o_busy,
    output logic                       o_err
);

    localparam int DIFF_W = SAMPLE_WIDTH + 1;
    localparam int SUM_W  = ((COST_WIDTH > DIFF_W) ? COST_WIDTH : DIFF_W) + 1;
    localparam logic [COST_WIDTH-1:0] COST_MAX  = '1;
    localparam logic [POS_WIDTH:0]    REF_MAX_L = (POS_WIDTH + 1)'(REF_MAX);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROW, S_OUT} state_t;

    function automatic logic [COST_WIDTH-1:0] sat_add(input logic [COST_WIDTH-1:0] a,
                                                      input logic [DIFF_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'(COST_MAX)) ? COST_MAX : s[COST_WIDTH-1:0];
    endfunction

    function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [SAMPLE_WIDTH-1:0] a,
                                                   input logic signed [SAMPLE_WIDTH-1:0] b);
        logic signed [DIFF_W-1:0] t;
        t = $signed({a[SAMPLE_WIDTH-1], a}) - $signed({b[SAMPLE_WIDTH-1], b});
        return t[DIFF_W-1] ? $unsigned(-t) : $unsigned(t);
    endfunction

    function automatic logic [COST_WIDTH-1:0] min3(input logic [COST_WIDTH-1:0] a,
                                                   input logic [COST_WIDTH-1:0] b,
                                                   input logic [COST_WIDTH-1:0] c);
        logic [COST_WIDTH-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    state_t state, state_nxt;

    logic signed [SAMPLE_WIDTH-1:0] ref_mem [REF_MAX];
    logic [COST_WIDTH-1:0]          row_mem [REF_MAX];

    logic [POS_WIDTH:0]   wr_ptr, ref_len;
    logic [POS_WIDTH-1:0] j;
    logic                 mode_r, last_r, in_query, out_beat, err;

    logic signed [SAMPLE_WIDTH-1:0] q_p1;
    logic [COST_WIDTH-1:0]          d_left_p1, dprev_left_p1, min_cost_p1, res_cost_p1;
    logic [POS_WIDTH-1:0]           min_pos_p1, res_pos_p1;

    logic                           in_fire, row_last, ref_wr, take_min_p0;
    logic [POS_WIDTH-1:0]           ref_wr_idx;
    logic signed [SAMPLE_WIDTH-1:0] sample;
    logic [DIFF_W-1:0]              d_p0;
    logic [COST_WIDTH-1:0]          dprev_p0, cost_p0;
    logic                           unused_hi;

    assign unused_hi        = ^i_axis_in_tdata[AXIS_DATA_WIDTH-1:SAMPLE_WIDTH];
    assign sample           = $signed(i_axis_in_tdata[SAMPLE_WIDTH-1:0]);
    assign o_axis_in_tready = i_axis_rst && (state == S_IDLE || state == S_LOAD);
    assign in_fire          = i_axis_in_tvalid && o_axis_in_tready;
    assign row_last         = ((POS_WIDTH + 1)'(j) == ref_len - 1'b1);
    assign ref_wr           = in_fire && ((state == S_IDLE && i_axis_in_tuser) ||
                                          (state == S_LOAD && wr_ptr < REF_MAX_L));
    assign ref_wr_idx       = (state == S_IDLE) ? '0 : wr_ptr[POS_WIDTH-1:0];

    // Cell stage: one DP cell evaluated combinationally per ROW cycle
    assign d_p0     = abs_diff(q_p1, ref_mem[j]);
    assign dprev_p0 = row_mem[j];

    always_comb begin
        cost_p0 = '0;
        if (!in_query) begin
            if (mode_r || j == '0) cost_p0 = sat_add('0, d_p0);
            else                   cost_p0 = sat_add(d_left_p1, d_p0);
        end else if (j == '0) begin
            cost_p0 = sat_add(dprev_p0, d_p0);
        end else begin
            cost_p0 = sat_add(min3(dprev_p0, d_left_p1, dprev_left_p1), d_p0);
        end
    end

    assign take_min_p0 = (j == '0) || (cost_p0 < min_cost_p1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (in_fire) begin
                if (i_axis_in_tuser) begin
                    if (!i_axis_in_tlast) state_nxt = S_LOAD;
                end else if (ref_len != '0) begin
                    state_nxt = S_ROW;
                end
            end
            S_LOAD: if (in_fire && i_axis_in_tlast) state_nxt = S_IDLE;
            S_ROW:  if (row_last) state_nxt = last_r ? S_OUT : S_IDLE;
            S_OUT:  if (out_beat && i_axis_out_tready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
        if (!i_axis_rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            ref_len  <= '0;
            j        <= '0;
            mode_r   <= 1'b0;
            last_r   <= 1'b0;
            in_query <= 1'b0;
            out_beat <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: if (in_fire) begin
                    if (i_axis_in_tuser) begin
                        wr_ptr   <= (POS_WIDTH + 1)'(1);
                        ref_len  <= i_axis_in_tlast ? (POS_WIDTH + 1)'(1) : '0;
                        in_query <= 1'b0;
                    end else if (ref_len == '0) begin
                        err <= 1'b1;
                    end else begin
                        j      <= '0;
                        last_r <= i_axis_in_tlast;
                        if (!in_query) mode_r <= i_mode;
                    end
                end
                S_LOAD: if (in_fire) begin
                    if (wr_ptr < REF_MAX_L) wr_ptr <= wr_ptr + 1'b1;
                    else                    err    <= 1'b1;
                    if (i_axis_in_tlast)
                        ref_len <= (wr_ptr < REF_MAX_L) ? wr_ptr + 1'b1 : REF_MAX_L;
                end
                S_ROW: begin
                    out_beat <= 1'b0;
                    if (row_last) begin
                        j        <= '0;
                        in_query <= !last_r;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                S_OUT: if (i_axis_out_tready) out_beat <= !out_beat;
                default: ;
            endcase
        end
    end

    // Row stage: commit the cell to the row buffer and the neighbour registers
    always_ff @(posedge i_axis_clk) begin
        if (ref_wr) ref_mem[ref_wr_idx] <= sample;
        if (state == S_IDLE && in_fire && !i_axis_in_tuser) q_p1 <= sample;
        if (state == S_ROW) begin
            row_mem[j]    <= cost_p0;
            d_left_p1     <= cost_p0;
            dprev_left_p1 <= dprev_p0;
            if (take_min_p0) begin
                min_cost_p1 <= cost_p0;
                min_pos_p1  <= j;
            end
            if (row_last && last_r) begin
                res_cost_p1 <= (mode_r && !take_min_p0) ? min_cost_p1 : cost_p0;
                res_pos_p1  <= (mode_r && !take_min_p0) ? min_pos_p1  : j;
            end
        end
    end

    assign o_axis_out_tvalid = (state == S_OUT);
    assign o_axis_out_tuser  = (state == S_OUT) && !out_beat;
    assign o_axis_out_tlast  = (state == S_OUT) && out_beat;
    assign o_axis_out_tdata  = (state != S_OUT) ? '0 :
                               out_beat ? AXIS_DATA_WIDTH'(res_pos_p1) : AXIS_DATA_WIDTH'(res_cost_p1);
    assign o_ref_len         = ref_len;
    assign o_busy            = (state == S_ROW) || (state == S_OUT);
    assign o_err             = err;

endmodule
